pwm_multi_ch: RTL and testbench
===============================

// Module: pwm_multi_ch
// PURPOSE
//  Multi-channel PWM generator: NCH outputs share one period counter; each channel has its own duty.
//  Edge-aligned or center-aligned counting, per-channel output inversion.
//  Glitch-free config updates: new settings are double-buffered and applied only at a period boundary.
//  Drives motor/LED/servo outputs; the config is written by a local register block.
// PARAMETERS
//  NCH    4    number of PWM channels (>=1)
//  CW     16   counter/period/duty width in bits (>=2)
//  P_DEF  999  active period value after reset (must fit in CW bits)
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       synchronous reset, active-high
//  en          in   1       run enable; low = counter cleared, outputs idle
//  cfg_wr      in   1       1-cycle strobe; captures period_in/duty_in/center_in/inv_in
//  period_in   in   CW      period value P
//  duty_in     in   NCH*CW  duty D[i] = duty_in[i*CW +: CW]
//  center_in   in   1       0 = edge-aligned, 1 = center-aligned
//  inv_in      in   NCH     per-channel output inversion
//  wave        out  NCH     registered PWM outputs
//  cycle_start out  1       registered 1-cycle pulse marking the first cycle of each period
//  cfg_pending out  1       captured config is waiting for a boundary
// BEHAVIOUR
//  Reset: cnt=0, dir=up, active P=P_DEF, D[*]=0, center=0, inv=0, pending=0, wave=0, cycle_start=0.
//  Config registers: a pending set plus an active set. cfg_wr writes the pending set and sets cfg_pending=1.
//   A later cfg_wr overwrites the pending set (last write wins).
//  Edge mode: cnt counts 0,1..P, then wraps to 0. Period = P+1 cycles. Boundary = cycle with cnt==P.
//  Center mode, P>=1: cnt runs up 0..P-1, then down P-1..0. Each endpoint is held 2 cycles. Period = 2P cycles.
//   dir flips at the endpoints. Boundary = cycle with dir==down and cnt==0.
//  Center mode, P==0: behaves as edge mode with P=0 (cnt held at 0, boundary every cycle).
//  Compare: raw[i] = (cnt < D[i]); wave[i] <= raw[i] ^ inv[i]. wave lags cnt by exactly 1 cycle.
//   Edge high time  = min(D, P+1) of every P+1 cycles.
//   Center high time = min(2D, 2P) of every 2P cycles, centred on the boundary.
//   D=0 gives a constant low level; D>P (edge) or D>=P (center) gives a constant high level (before inversion).
//  At a boundary (en=1):
//   - cnt <= 0, dir <= up, cycle_start <= 1.
//   - If cfg_pending: active set <= pending set, cfg_pending <= 0.
//  cfg_wr in a boundary cycle: the port values go straight into the active set; cfg_pending stays 0.
//  en=0:
//   - cnt <= 0, dir <= up, cycle_start <= 0, wave[i] <= inv[i] (idle level).
//   - Any pending set is applied immediately, in the same cycle.
//   - cfg_wr while en=0 loads the active set directly.
//  en 0->1: the first cycle with en=1 has cnt=0 and is treated as period start, so cycle_start is high next cycle.
//   wave follows the normal compare from that cycle's cnt.
//  All arithmetic is unsigned CW-bit. cnt never exceeds P, so it cannot overflow.
//  rst mid-operation: all state returns to reset values on the next edge. The pending set is discarded.
// TESTING
//  1 Reset, en=1, no cfg: P=999, D=0 -> wave=0 throughout; cycle_start every 1000 cycles.
//  2 cfg_wr P=9, D0=3, D1=10, edge, en=0 -> en=1: wave0 high 3 of every 10 cycles; wave1 constant 1;
//    cycle_start period 10.
//  3 Center mode, P=4, D0=1 -> cnt 0,1,2,3,3,2,1,0,0..; wave0 high 2 of every 8 cycles around the boundary.
//  4 Mid-period cfg_wr D0=5 at cnt=2 -> cfg_pending=1, old duty continues; new duty from cnt=0 of the
//    next period; pending clears.
//  5 cfg_wr in the boundary cycle (cnt==P) -> new values active at the next cnt=0; cfg_pending never asserts.
//  6 inv0=1, en dropped mid-period -> wave0=1 (idle) the next cycle, cnt=0; rst mid-period -> all outputs 0,
//    P back to 999.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch
//   Multi-channel PWM generator. All NCH channels share one period counter;
//   each channel compares the counter against its own duty value. Supports
//   edge-aligned (sawtooth) and center-aligned (triangle) counting and
//   per-channel output inversion. Configuration is double-buffered so a
//   running waveform never sees a partial period.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous reset, active-high
//   en           run enable; low clears the counter and idles the outputs
//   cfg_wr       1-cycle write strobe for period_in/duty_in/center_in/inv_in
//   period_in    period value P (CW bits)
//   duty_in      packed duties, D[i] = duty_in[i*CW +: CW]
//   center_in    0 = edge-aligned, 1 = center-aligned
//   inv_in       per-channel output inversion
//   wave         registered PWM outputs (lag cnt by one cycle)
//   cycle_start  registered pulse marking the start of a period
//   cfg_pending  a captured config is waiting for a period boundary
//
// Config write semantics: cfg_wr is a strobe with no back-pressure. Every
// asserted cycle is accepted. While running and away from a boundary the
// values go into the pending set (last write wins). In a boundary cycle, or
// while en=0, they go straight into the active set.
module pwm_multi_ch #(
    parameter int NCH   = 4,
    parameter int CW    = 16,
    parameter int P_DEF = 999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_wr,
    input  logic [CW-1:0]     period_in,
    input  logic [NCH*CW-1:0] duty_in,
    input  logic              center_in,
    input  logic [NCH-1:0]    inv_in,
    output logic [NCH-1:0]    wave,
    output logic              cycle_start,
    output logic              cfg_pending
);

    localparam logic [CW-1:0] P_RST = CW'(P_DEF);

    // Active configuration
    logic [CW-1:0]     act_p;
    logic [NCH*CW-1:0] act_d;
    logic              act_c;
    logic [NCH-1:0]    act_inv;

    // Pending configuration
    logic [CW-1:0]     pnd_p;
    logic [NCH*CW-1:0] pnd_d;
    logic              pnd_c;
    logic [NCH-1:0]    pnd_inv;

    logic [CW-1:0]     cnt;
    logic              dir_down;
    logic              en_q;      // en in the previous cycle, detects 0->1

    logic              center_run;
    logic              boundary;
    logic [CW-1:0]     cnt_nxt;
    logic              dir_nxt;
    logic [NCH-1:0]    raw;

    // Center mode with P==0 degenerates to edge mode with P==0.
    assign center_run = act_c && (act_p != '0);
    assign boundary   = center_run ? (dir_down && (cnt == '0)) : (cnt == act_p);

    // Counter advance away from a boundary. In center mode the top endpoint
    // P-1 is held for two cycles by flipping dir without moving cnt; the
    // bottom endpoint is held by the boundary reset to 0/up.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir_down;
        if (center_run) begin
            if (!dir_down) begin
                if (cnt == act_p - 1'b1) begin
                    dir_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NCH; i++) begin
            raw[i] = (cnt < act_d[i*CW +: CW]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dir_down    <= 1'b0;
            en_q        <= 1'b0;
            act_p       <= P_RST;
            act_d       <= '0;
            act_c       <= 1'b0;
            act_inv     <= '0;
            pnd_p       <= '0;
            pnd_d       <= '0;
            pnd_c       <= 1'b0;
            pnd_inv     <= '0;
            cfg_pending <= 1'b0;
            wave        <= '0;
            cycle_start <= 1'b0;
        end else if (!en) begin
            cnt         <= '0;
            dir_down    <= 1'b0;
            en_q        <= 1'b0;
            cycle_start <= 1'b0;
            wave        <= act_inv;
            cfg_pending <= 1'b0;
            if (cfg_wr) begin
                act_p   <= period_in;
                act_d   <= duty_in;
                act_c   <= center_in;
                act_inv <= inv_in;
            end else if (cfg_pending) begin
                act_p   <= pnd_p;
                act_d   <= pnd_d;
                act_c   <= pnd_c;
                act_inv <= pnd_inv;
            end
        end else begin
            en_q        <= 1'b1;
            wave        <= raw ^ act_inv;
            // The first enabled cycle counts as a period start.
            cycle_start <= boundary || !en_q;
            if (boundary) begin
                cnt         <= '0;
                dir_down    <= 1'b0;
                cfg_pending <= 1'b0;
                if (cfg_wr) begin
                    act_p   <= period_in;
                    act_d   <= duty_in;
                    act_c   <= center_in;
                    act_inv <= inv_in;
                end else if (cfg_pending) begin
                    act_p   <= pnd_p;
                    act_d   <= pnd_d;
                    act_c   <= pnd_c;
                    act_inv <= pnd_inv;
                end
            end else begin
                cnt      <= cnt_nxt;
                dir_down <= dir_nxt;
                if (cfg_wr) begin
                    pnd_p       <= period_in;
                    pnd_d       <= duty_in;
                    pnd_c       <= center_in;
                    pnd_inv     <= inv_in;
                    cfg_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch
//   Drives pwm_multi_ch with directed scenarios followed by random traffic.
//   A reference model tracks the position inside the current period and
//   derives the counter value arithmetically; the expected registered
//   outputs {cfg_pending, cycle_start, wave} are queued per cycle and a
//   monitor compares them one cycle later.
module tb_pwm_multi_ch;

    localparam int NCH   = 4;
    localparam int CW    = 16;
    localparam int P_DEF = 999;
    localparam int OW    = NCH + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              en;
    logic              cfg_wr;
    logic [CW-1:0]     period_in;
    logic [NCH*CW-1:0] duty_in;
    logic              center_in;
    logic [NCH-1:0]    inv_in;
    logic [NCH-1:0]    wave;
    logic              cycle_start;
    logic              cfg_pending;

    pwm_multi_ch #(.NCH(NCH), .CW(CW), .P_DEF(P_DEF)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_wr      (cfg_wr),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .center_in   (center_in),
        .inv_in      (inv_in),
        .wave        (wave),
        .cycle_start (cycle_start),
        .cfg_pending (cfg_pending)
    );

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  started  = 1'b0;

    // ---------------- reference model ----------------
    int             m_t;        // cycle index inside the current period
    int             m_p;
    int             m_d [NCH];
    bit             m_c;
    logic [NCH-1:0] m_inv;
    int             q_p;
    int             q_d [NCH];
    bit             q_c;
    logic [NCH-1:0] q_inv;
    bit             m_pend;
    bit             m_enq;

    // Config values presented on a write
    int                cfg_p;
    logic [NCH*CW-1:0] cfg_d;
    bit                cfg_c;
    logic [NCH-1:0]    cfg_inv;

    function automatic void model_reset();
        m_t = 0; m_p = P_DEF; m_c = 0; m_inv = '0;
        q_p = 0; q_c = 0; q_inv = '0;
        for (int i = 0; i < NCH; i++) begin
            m_d[i] = 0;
            q_d[i] = 0;
        end
        m_pend = 0; m_enq = 0;
    endfunction

    function automatic bit model_center();
        return m_c && (m_p != 0);
    endfunction

    function automatic int model_len();
        return model_center() ? 2 * m_p : m_p + 1;
    endfunction

    // Triangle: positions 0..P-1 count up, positions P..2P-1 mirror back down.
    function automatic int model_cnt();
        if (model_center())
            return (m_t < m_p) ? m_t : 2 * m_p - 1 - m_t;
        return m_t;
    endfunction

    function automatic bit model_boundary();
        return m_t == model_len() - 1;
    endfunction

    function automatic void apply_ports();
        m_p = cfg_p; m_c = cfg_c; m_inv = cfg_inv;
        for (int i = 0; i < NCH; i++) m_d[i] = int'(cfg_d[i*CW +: CW]);
    endfunction

    function automatic void apply_pend();
        m_p = q_p; m_c = q_c; m_inv = q_inv;
        for (int i = 0; i < NCH; i++) m_d[i] = q_d[i];
    endfunction

    function automatic void save_pend();
        q_p = cfg_p; q_c = cfg_c; q_inv = cfg_inv;
        for (int i = 0; i < NCH; i++) q_d[i] = int'(cfg_d[i*CW +: CW]);
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit e, input bit w);
        logic [NCH-1:0] ew;
        bit             ecs;
        int             c;
        bit             bnd;
        @(negedge clk);
        rst    = r;
        en     = e;
        cfg_wr = w;
        if (w) begin
            period_in = CW'(cfg_p);
            duty_in   = cfg_d;
            center_in = cfg_c;
            inv_in    = cfg_inv;
        end else begin
            // Ports must be ignored without a strobe.
            period_in = CW'($urandom);
            duty_in   = {NCH{16'($urandom)}};
            center_in = 1'($urandom);
            inv_in    = NCH'($urandom);
        end
        ew = '0;
        if (r) begin
            model_reset();
            exp_q.push_back('0);
        end else if (!e) begin
            ew = m_inv;
            m_t = 0;
            m_enq = 0;
            if (w) apply_ports();
            else if (m_pend) apply_pend();
            m_pend = 0;
            exp_q.push_back({1'b0, 1'b0, ew});
        end else begin
            c = model_cnt();
            for (int i = 0; i < NCH; i++) ew[i] = (c < m_d[i]) ^ m_inv[i];
            bnd = model_boundary();
            ecs = bnd || !m_enq;
            m_enq = 1;
            if (bnd) begin
                m_t = 0;
                if (w) apply_ports();
                else if (m_pend) apply_pend();
                m_pend = 0;
            end else begin
                m_t++;
                if (w) begin
                    save_pend();
                    m_pend = 1;
                end
            end
            exp_q.push_back({m_pend, ecs, ew});
        end
        started = 1'b1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0);
    endtask

    task automatic set_cfg(input int p, input int d0, input int d1, input int d2,
                           input int d3, input bit c, input logic [NCH-1:0] iv);
        cfg_p   = p;
        cfg_d   = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
        cfg_c   = c;
        cfg_inv = iv;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [OW-1:0] act;
        logic [OW-1:0] exp_v;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            act = {cfg_pending, cycle_start, wave};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL queue_underflow t=%0t act=%b", $time, act);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    failures++;
                    $display("FAIL outputs t=%0t {pend,cs,wave} act=%b exp=%b",
                             $time, act, exp_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b0; cfg_wr = 1'b0;
        period_in = '0; duty_in = '0; center_in = 1'b0; inv_in = '0;
        set_cfg(0, 0, 0, 0, 0, 0, '0);
        model_reset();

        // Reset, then free-run with defaults (P=999, D=0).
        repeat (3) step(1, 0, 0);
        run(2050);

        // Edge mode P=9, loaded while disabled.
        set_cfg(9, 3, 10, 0, 9, 0, 4'b0000);
        step(0, 0, 1);
        repeat (2) step(0, 0, 0);
        run(40);

        // Center mode P=4, written while running (waits for a boundary).
        set_cfg(4, 1, 4, 2, 5, 1, 4'b0000);
        step(0, 1, 1);
        run(40);

        // Mid-period duty change at cnt==2 in edge mode.
        set_cfg(9, 3, 1, 7, 0, 0, 4'b0000);
        step(0, 1, 1);
        run(12);
        for (int k = 0; k < 30 && !(model_cnt() == 2 && !model_boundary()); k++) step(0, 1, 0);
        set_cfg(9, 5, 1, 7, 0, 0, 4'b0000);
        step(0, 1, 1);
        run(30);

        // Write exactly in the boundary cycle.
        for (int k = 0; k < 30 && !model_boundary(); k++) step(0, 1, 0);
        set_cfg(9, 8, 2, 9, 4, 0, 4'b0000);
        step(0, 1, 1);
        run(25);

        // Inversion, en drop mid-period, then reset mid-period.
        set_cfg(6, 2, 3, 0, 7, 0, 4'b0001);
        step(0, 0, 1);
        run(15);
        repeat (3) step(0, 0, 0);
        run(7);
        step(1, 1, 0);
        run(1010);

        // Random traffic, including P=0 and center/edge switching.
        for (int k = 0; k < 3000; k++) begin
            bit r, e, w;
            r = ($urandom_range(0, 999) == 0);
            e = ($urandom_range(0, 49) != 0);
            w = ($urandom_range(0, 11) == 0);
            if (w) begin
                set_cfg($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14),
                        $urandom_range(0, 14), $urandom_range(0, 14),
                        1'($urandom_range(0, 1)), NCH'($urandom_range(0, 15)));
            end
            step(r, e, w);
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
